// File: rtl/tt_scan_ctrl.sv
// Truth-table scan sequencer for a 3-input function unit.
// Sweeps A/B/C through 0..7, samples F after a settle window, publishes the table.
module tt_scan_ctrl #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] exp_table,
    input  logic       f_in,
    output logic       drv_a,
    output logic       drv_b,
    output logic       drv_c,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic [3:0] ones_cnt,
    output logic       mismatch
);

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t     state;
    state_t     state_d;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic [7:0] work;
    logic [7:0] exp_q;
    logic [7:0] final_tab;
    logic [3:0] pop;
    logic       accept;
    logic       settled;
    logic       finish;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        accept    = 1'b0;
        finish    = 1'b0;
        settled   = (cnt == SETTLE_C);
        final_tab = work;
        final_tab[idx] = f_in;
        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SCAN;
                    accept  = 1'b1;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (settled && idx == 3'd7) begin
                    state_d = IDLE;
                    finish  = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        pop = 4'd0;
        for (int i = 0; i < 8; i++) pop = pop + {3'b000, final_tab[i]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 3'd0;
            cnt       <= 4'd0;
            work      <= 8'h00;
            exp_q     <= 8'h00;
            done      <= 1'b0;
            table_out <= 8'h00;
            ones_cnt  <= 4'd0;
            mismatch  <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                idx   <= 3'd0;
                cnt   <= 4'd0;
                work  <= 8'h00;
                exp_q <= exp_table;
            end else if (state == SCAN && !abort) begin
                if (!settled) begin
                    cnt <= cnt + 4'd1;
                end else begin
                    cnt  <= 4'd0;
                    work <= final_tab;
                    if (idx != 3'd7) idx <= idx + 3'd1;
                end
            end
            // Results move only on a clean completion; aborts leave them intact
            if (finish) begin
                table_out <= final_tab;
                ones_cnt  <= pop;
                mismatch  <= (final_tab != exp_q);
            end
        end
    end

    assign busy  = (state == SCAN);
    assign drv_a = busy & idx[2];
    assign drv_b = busy & idx[1];
    assign drv_c = busy & idx[0];

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Directed bench for tt_scan_ctrl: one instance with SETTLE=0, one with SETTLE=2.
module tb_tt_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start0, abort0, f0, a0, b0, c0, busy0, done0, mis0;
    logic [7:0] exp0, tab0;
    logic [3:0] ones0;
    logic       start2, abort2, f2, a2, b2, c2, busy2, done2, mis2;
    logic [7:0] exp2, tab2;
    logic [3:0] ones2;
    logic [1:0] dly;

    int n_vec = 0;
    int n_bad = 0;
    int cyc;

    always #5 clk = ~clk;

    tt_scan_ctrl #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0),
        .exp_table(exp0), .f_in(f0), .drv_a(a0), .drv_b(b0), .drv_c(c0),
        .busy(busy0), .done(done0), .table_out(tab0), .ones_cnt(ones0),
        .mismatch(mis0)
    );

    tt_scan_ctrl #(.SETTLE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .exp_table(exp2), .f_in(f2), .drv_a(a2), .drv_b(b2), .drv_c(c2),
        .busy(busy2), .done(done2), .table_out(tab2), .ones_cnt(ones2),
        .mismatch(mis2)
    );

    // Unit models: minterms 0,1 combinational; parity with 2-cycle delay
    assign f0 = ~a0 & ~b0;
    always @(posedge clk) dly <= {dly[0], a2 ^ b2 ^ c2};
    assign f2 = dly[1];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic scan0(input logic [7:0] e, input bit hold);
        int bad;
        int seen;
        bad = 0;
        @(negedge clk);
        start0 = 1'b1;
        exp0   = e;
        @(negedge clk);
        if (!hold) start0 = 1'b0;
        chk("s0_accept", {busy0, a0, b0, c0}, 4'b1000);
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n < 8 && ({a0, b0, c0} != n[2:0] || !busy0 || done0)) bad++;
        end
        chk("s0_steps", bad, 0);
        chk("s0_done", {done0, busy0}, 2'b10);
        if (hold) begin
            @(negedge clk);
            chk("s0_reaccept", {busy0, done0, a0, b0, c0}, 5'b10000);
            start0 = 1'b0;
            seen = 0;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (done0) begin
                    seen = 1;
                    break;
                end
            end
            chk("s0_second_done", seen, 1);
        end
    endtask

    task automatic scan2(input logic [7:0] e, input bit pulse,
                         output int c);
        int bad;
        bad = 0;
        c   = -1;
        @(negedge clk);
        start2 = 1'b1;
        exp2   = e;
        @(negedge clk);
        start2 = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (pulse && n == 10) start2 = 1'b1;
            if (n == 11) start2 = 1'b0;
            if (done2) begin
                c = n;
                break;
            end
            if (n < 24 && ({busy2, a2, b2, c2} != {1'b1, 3'(n / 3)})) bad++;
        end
        chk("s2_latency", c, 24);
        chk("s2_hold", bad, 0);
    endtask

    initial begin
        int saw;
        rst_n  = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; exp0 = 8'h00;
        start2 = 1'b0; abort2 = 1'b0; exp2 = 8'h00;
        #3;
        chk("rst0", {busy0, done0, a0, b0, c0, mis0, ones0, tab0}, 0);
        chk("rst2", {busy2, done2, a2, b2, c2, mis2, ones2, tab2}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        scan0(8'h03, 1'b0);
        chk("s0_tab", tab0, 8'h03);
        chk("s0_ones", ones0, 2);
        chk("s0_mis", mis0, 0);

        scan2(8'h96, 1'b0, cyc);
        chk("s2_tab", tab2, 8'h96);
        chk("s2_ones", ones2, 4);
        chk("s2_mis", mis2, 0);

        scan2(8'h97, 1'b0, cyc);
        chk("s2_tab_bad", tab2, 8'h96);
        chk("s2_mis_bad", mis2, 1);
        scan2(8'h96, 1'b0, cyc);
        chk("s2_mis_clr", mis2, 0);

        @(negedge clk);
        start0 = 1'b1;
        abort0 = 1'b1;
        @(negedge clk);
        chk("both_high", busy0, 0);
        start0 = 1'b0;
        abort0 = 1'b0;

        @(negedge clk);
        start0 = 1'b1;
        exp0   = 8'h03;
        @(negedge clk);
        start0 = 1'b0;
        repeat (4) @(negedge clk);
        chk("ab_idx4", {busy0, a0, b0, c0}, 4'b1100);
        abort0 = 1'b1;
        @(negedge clk);
        abort0 = 1'b0;
        chk("ab_idle", {busy0, a0, b0, c0, done0}, 0);
        saw = 0;
        repeat (12) begin
            @(negedge clk);
            if (done0) saw = 1;
        end
        chk("ab_nodone", saw, 0);
        chk("ab_tab", tab0, 8'h03);
        chk("ab_ones", ones0, 2);

        scan0(8'h03, 1'b1);
        scan2(8'h96, 1'b1, cyc);
        chk("pulse_tab", tab2, 8'h96);

        @(negedge clk);
        start2 = 1'b1;
        exp2   = 8'h96;
        @(negedge clk);
        start2 = 1'b0;
        repeat (15) @(negedge clk);
        chk("rs_idx5", {busy2, a2, b2, c2}, 4'b1101);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_out2", {busy2, done2, a2, b2, c2, mis2, ones2, tab2}, 0);
        chk("rs_tab0", tab0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        scan2(8'h96, 1'b0, cyc);
        chk("rs_tab", tab2, 8'h96);
        chk("rs_ones", ones2, 4);
        chk("rs_mis", mis2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
